// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: turns SPI command/data byte streams into register-bank accesses.
//   Command bytes (dc_i=0) select the mode: 8'h2a = write burst, 8'h3b = read
//   burst, anything else = ignore. In a write burst, every four data bytes are
//   assembled little-endian into one 32-bit word and written with a
//   single-cycle strobe. In a read burst, each data byte issues a read request
//   that carries the word address and the byte lane.
//
// Optional feature: SPI_REG_CTRL_ADDR_WRAP_EN
//   defined   - after the last register the address wraps to 0 and the burst
//               continues
//   undefined - after the last register the block parks in IGNORE until the
//               next command byte
//
// Ports:
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   dc_i               0 = command byte, 1 = data byte (sampled with the valid)
//   spi_byte_vld_i     one-cycle byte-valid strobe
//   spi_byte_data_i    received byte
//   reg_wr_en_o        one-cycle write strobe, 1 cycle after the 4th byte
//   reg_wr_addr_o      write word address (the address being written)
//   reg_wr_data_o      write word, held between strobes
//   reg_rd_en_o        combinational read strobe
//   reg_rd_addr_o      read word address
//   reg_rd_byte_o      read byte lane
//   busy_o             1 while in WR or RD
module spi_reg_ctrl #(
    parameter int REG_NUM = 8,
    localparam int ADDR_W = $clog2(REG_NUM)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              dc_i,
    input  logic              spi_byte_vld_i,
    input  logic [7:0]        spi_byte_data_i,
    output logic              reg_wr_en_o,
    output logic [ADDR_W-1:0] reg_wr_addr_o,
    output logic [31:0]       reg_wr_data_o,
    output logic              reg_rd_en_o,
    output logic [ADDR_W-1:0] reg_rd_addr_o,
    output logic [1:0]        reg_rd_byte_o,
    output logic              busy_o
);

    localparam logic [7:0] CONF_WR = 8'h2a;
    localparam logic [7:0] DATA_RD = 8'h3b;

    typedef enum logic [1:0] {IDLE, WR, RD, IGNORE} state_t;

    state_t            state, state_nxt;
    logic [1:0]        cnt;        // byte counter, doubles as the read byte lane
    logic [31:0]       shreg;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              cmd_vld, dat_vld;
    logic              wr_last, rd_last, at_end;

    assign cmd_vld = spi_byte_vld_i & ~dc_i;
    assign dat_vld = spi_byte_vld_i & dc_i;

    // last byte of a word in the current burst
    assign wr_last = (state == WR) & dat_vld & (cnt == 2'd3);
    assign rd_last = (state == RD) & dat_vld & (cnt == 2'd3);

`ifdef SPI_REG_CTRL_ADDR_WRAP_EN
    // the address counters simply roll over, so the burst never ends on its own
    assign at_end = 1'b0;
`else
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(REG_NUM - 1);
    assign at_end = (state == WR) ? (wr_addr == LAST) : (rd_addr == LAST);
`endif

    assign reg_rd_en_o   = (state == RD) & dat_vld;
    assign reg_rd_addr_o = rd_addr;
    assign reg_rd_byte_o = cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_o <= (state_nxt == WR) || (state_nxt == RD);
        end
    end

    always_comb begin
        state_nxt = state;
        if (cmd_vld) begin
            case (spi_byte_data_i)
                CONF_WR: state_nxt = WR;
                DATA_RD: state_nxt = RD;
                default: state_nxt = IGNORE;
            endcase
        end else if ((wr_last || rd_last) && at_end) begin
            state_nxt = IGNORE;
        end
    end

    // Datapath. The write strobe is registered from the 4th byte, so a command
    // arriving in the strobe cycle cannot cancel it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt           <= 2'd0;
            shreg         <= 32'd0;
            wr_addr       <= '0;
            rd_addr       <= '0;
            reg_wr_en_o   <= 1'b0;
            reg_wr_addr_o <= '0;
            reg_wr_data_o <= 32'd0;
        end else begin
            reg_wr_en_o <= wr_last;
            if (cmd_vld) begin
                cnt     <= 2'd0;
                shreg   <= 32'd0;
                wr_addr <= '0;
                rd_addr <= '0;
            end else if (dat_vld && (state == WR || state == RD)) begin
                cnt <= cnt + 2'd1;
                if (state == WR) begin
                    // shifting in from the top leaves byte n in bits [8n+7:8n]
                    shreg <= {spi_byte_data_i, shreg[31:8]};
                    if (cnt == 2'd3) begin
                        reg_wr_data_o <= {spi_byte_data_i, shreg[31:8]};
                        reg_wr_addr_o <= wr_addr;
                        wr_addr       <= wr_addr + 1'b1;
                    end
                end else if (cnt == 2'd3) begin
                    rd_addr <= rd_addr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
module tb_spi_reg_ctrl;

    localparam int REG_NUM = 8;
    localparam int ADDR_W  = $clog2(REG_NUM);
`ifdef SPI_REG_CTRL_ADDR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam int M_IDLE = 0, M_WR = 1, M_RD = 2, M_IGN = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              dc, vld;
    logic [7:0]        bdat;
    logic              wr_en, rd_en, busy;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [31:0]       wr_data;
    logic [1:0]        rd_byte;

    int n_chk = 0, n_err = 0, n_wr = 0;

    // reference model: mode, data bytes since last command, word assembly
    int          m_mode = M_IDLE;
    int          m_n    = 0;
    logic [7:0]  m_w [4];
    logic [31:0] m_last_wd = 32'd0;

    always #5 clk = ~clk;

    spi_reg_ctrl #(.REG_NUM(REG_NUM)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .dc_i           (dc),
        .spi_byte_vld_i (vld),
        .spi_byte_data_i(bdat),
        .reg_wr_en_o    (wr_en),
        .reg_wr_addr_o  (wr_addr),
        .reg_wr_data_o  (wr_data),
        .reg_rd_en_o    (rd_en),
        .reg_rd_addr_o  (rd_addr),
        .reg_rd_byte_o  (rd_byte),
        .busy_o         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // one clock cycle of stimulus, with the model stepped and outputs checked
    task automatic cyc(input logic d, input logic v, input logic [7:0] b);
        bit          erd, ewr;
        int          era, erl, ewa;
        logic [31:0] ewd;
        erd = 0; ewr = 0; era = 0; erl = 0; ewa = 0; ewd = 0;
        @(negedge clk);
        dc = d; vld = v; bdat = b;
        #1;
        if (v && !d) begin
            m_mode = (b == 8'h2a) ? M_WR : (b == 8'h3b) ? M_RD : M_IGN;
            m_n    = 0;
        end else if (v && d && m_mode == M_RD) begin
            erd = 1; era = (m_n / 4) % REG_NUM; erl = m_n % 4;
            m_n++;
            if (!WRAP && m_n == 4 * REG_NUM) m_mode = M_IGN;
        end else if (v && d && m_mode == M_WR) begin
            m_w[m_n % 4] = b;
            if (m_n % 4 == 3) begin
                ewr = 1; ewa = (m_n / 4) % REG_NUM;
                ewd = {m_w[3], m_w[2], m_w[1], m_w[0]};
            end
            m_n++;
            if (!WRAP && m_n == 4 * REG_NUM) m_mode = M_IGN;
        end
        chk("rd_en", rd_en, erd);
        if (erd) begin
            chk("rd_addr", rd_addr, era);
            chk("rd_byte", rd_byte, erl);
        end
        @(posedge clk);
        #1;
        chk("wr_en", wr_en, ewr);
        if (ewr) begin
            chk("wr_addr", wr_addr, ewa);
            chk("wr_data", wr_data, ewd);
            m_last_wd = ewd;
        end else begin
            chk("wr_hold", wr_data, m_last_wd);
        end
        if (wr_en) n_wr++;
        chk("busy", busy, (m_mode == M_WR || m_mode == M_RD));
    endtask

    task automatic cmd(input logic [7:0] c);
        cyc(1'b0, 1'b1, c);
    endtask

    task automatic dat(input logic [7:0] b);
        cyc(1'b1, 1'b1, b);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr_en"},   wr_en,   0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_rd_en"},   rd_en,   0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_rd_byte"}, rd_byte, 0);
        chk({tag, "_busy"},    busy,    0);
    endtask

    initial begin
        int base;
        int r;
        rst_n = 1'b0; dc = 1'b0; vld = 1'b0; bdat = 8'h00;
        #12;
        chk_zero("rst");
        rst_n = 1'b1;
        idle(3);
        chk_zero("idle");

        // write burst of two words
        cmd(8'h2a);
        base = n_wr;
        for (int i = 1; i <= 8; i++) dat(8'(i * 8'h11));
        chk("wr2_cnt", n_wr - base, 2);
        idle(2);

        // read burst of six bytes
        cmd(8'h3b);
        for (int i = 0; i < 6; i++) dat(8'($urandom));
        idle(1);

        // partial write discarded by a new command
        cmd(8'h2a);
        base = n_wr;
        dat(8'hde); dat(8'had);
        cmd(8'h3b);
        dat(8'h01);
        chk("partial_cnt", n_wr - base, 0);
        idle(1);

        // command right in the strobe cycle: strobe still fires
        cmd(8'h2a);
        for (int i = 0; i < 4; i++) dat(8'($urandom));
        cmd(8'h3b);
        dat(8'h00);

        // run past the last register
        cmd(8'h2a);
        base = n_wr;
        for (int i = 0; i < 4 * REG_NUM + 4; i++) dat(8'($urandom));
        chk("long_cnt", n_wr - base, WRAP ? REG_NUM + 1 : REG_NUM);
        idle(2);

        // read past the last register
        cmd(8'h3b);
        for (int i = 0; i < 4 * REG_NUM + 3; i++) dat(8'($urandom));

        // unknown command
        cmd(8'h5a);
        base = n_wr;
        for (int i = 0; i < 8; i++) dat(8'($urandom));
        chk("ign_cnt", n_wr - base, 0);

        // reset in the middle of a write burst
        cmd(8'h2a);
        dat(8'haa); dat(8'hbb); dat(8'hcc);
        @(negedge clk);
        vld = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        m_mode = M_IDLE; m_n = 0; m_last_wd = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        base = n_wr;
        dat(8'hdd);
        for (int i = 0; i < 4; i++) dat(8'($urandom));
        chk("rst_cnt", n_wr - base, 0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3)       cmd(8'h2a);
            else if (r < 6)  cmd(8'h3b);
            else if (r < 7)  cmd(8'($urandom));
            else if (r < 20) idle(1);
            else             dat(8'($urandom));
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
